sdram_word_sequencer: RTL and testbench
=======================================

Name: sdram_word_sequencer

Overview:
- Sits between the 32-bit AXI-Lite front-end and the 16-bit `sdram_controller` host interface, in the `clk_133mhz` domain.
- Accepts one 32-bit word request at a time and splits it into two 16-bit SDRAM accesses.
- Partial-halfword writes use read-modify-write, because the host interface has no byte mask.
- Returns one 32-bit read response, or a write completion, per request.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the request port. Bits [24:2] select the SDRAM word; upper bits are ignored.
- TIMEOUT_CYCLES, 1024, cycles to wait for rd_ready before aborting. Used only with SDRAM_SEQ_TIMEOUT_EN.

Ports:
- clk_133mhz  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored (word-aligned)
- req_wdata  in  32  write data
- req_wstrb  in  4  byte strobes
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes
- rsp_err  out  1  access aborted (timeout build only; else constant 0)
- wr_addr  out  24  halfword address to controller
- wr_data  out  16  halfword write data
- wr_enable  out  1  one-cycle write command pulse
- rd_addr  out  24  halfword read address
- rd_enable  out  1  one-cycle read command pulse
- rd_data  in  16  controller read data
- rd_ready  in  1  rd_data valid pulse
- busy  in  1  controller busy

Behaviour:
- Reset: state IDLE, req_ready=0 during reset and 1 the cycle after, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_enable=0, rd_enable=0, wr/rd addr and data=0, halfword counter h=0.
- Clock-domain rule: only clk_133mhz is used; the AXI-side CDC is outside this block.
- Capture: req_ready=1 only in IDLE. On req_valid&&req_ready, latch write, address, wdata and wstrb; set h=0.
- Halfword mapping: base={req_addr[24:2],1'b0}.
  - h=0 uses address base, bytes [15:0], strobes [1:0].
  - h=1 uses address base+1, bytes [31:16], strobes [3:2].
- States: IDLE, DECIDE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, NEXT, RESP.
- DECIDE:
  - Read → RD_ISSUE.
  - Write with both strobes of h set → WR_ISSUE.
  - Write with both strobes clear → NEXT (no SDRAM command).
  - Write with one strobe set → RD_ISSUE (RMW read).
- RD_ISSUE: wait until busy==0, then pulse rd_enable for exactly 1 cycle with rd_addr set → RD_WAIT.
- RD_WAIT: on rd_ready, capture rd_data.
  - Read: store into rsp_rdata half h → NEXT.
  - RMW: merge strobed bytes of wdata over rd_data into wr_data → WR_ISSUE.
  - rd_ready arriving in any other state is ignored.
- WR_ISSUE: wait until busy==0, then pulse wr_enable for 1 cycle → WR_WAIT.
- WR_WAIT: wait 1 cycle (busy-rise gap), then until busy==0 → NEXT.
- NEXT: if h==0, set h=1 → DECIDE; else → RESP.
- RESP: rsp_valid=1; rsp_rdata stable (0 for writes); hold until rsp_ready, then → IDLE.
- Latency: command issue is no earlier than 2 cycles after acceptance. A write with wstrb=0 reaches rsp_valid 5 cycles after acceptance.
- Never pulse rd_enable and wr_enable in the same cycle. Never issue any command while busy==1.
- Reset mid-operation: return to IDLE and drop all pulses and rsp_valid. A controller access already in flight completes on its own. The next command still waits for busy==0.

Optional Feature:
- SDRAM_SEQ_TIMEOUT_EN defined:
  - A counter runs in RD_WAIT and WR_WAIT.
  - After TIMEOUT_CYCLES cycles without exit, go to RESP with rsp_err=1 and rsp_rdata=32'hDEAD_BEEF.
  - Any remaining halfword of that request is skipped.
  - The counter clears on entry to each wait state.
- Undefined: no counter, waits are unbounded, rsp_err tied 0.

Test Plan:
- Full write addr 0x0000_0010, wdata 0xCAFE_BABE, wstrb 4'hF → wr pulses at 0x000008 data 0xBABE, then 0x000009 data 0xCAFE; rsp_valid with rsp_rdata=0.
- Read addr 0x10, model returns 0xBABE then 0xCAFE → rd pulses at 0x000008, 0x000009; rsp_rdata=0xCAFE_BABE.
- Partial write wstrb 4'b0010, wdata 0x0000_5500 over stored 0x1234 at h=0 → RMW: read then write 0x5534; no command issued for h=1.
- wstrb 4'h0 write → no rd/wr pulses; rsp_valid 5 cycles after acceptance; busy held high throughout → no issue until busy falls; then issue within 1 cycle.
- Assert reset during RD_WAIT → next cycle all outputs at reset values; new read then completes correctly; rsp_ready held low 10 cycles → rsp_valid and rsp_rdata stable, req_ready=0.
- (SDRAM_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16) read with rd_ready never asserted → rsp_err=1, rsp_rdata=0xDEAD_BEEF after 16 wait cycles.

Source files
------------

// File: rtl/sdram_word_sequencer.sv
// rtl/sdram_word_sequencer.sv - splits 32-bit word requests into two 16-bit SDRAM accesses with RMW
// Optional access timeout: define SDRAM_SEQ_TIMEOUT_EN.
module sdram_word_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_133mhz,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [23:0]           wr_addr,
  output logic [15:0]           wr_data,
  output logic                  wr_enable,
  output logic [23:0]           rd_addr,
  output logic                  rd_enable,
  input  logic [15:0]           rd_data,
  input  logic                  rd_ready,
  input  logic                  busy
);
  typedef enum logic [2:0] {
    IDLE, DECIDE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, NEXT, RESP
  } state_t;

  state_t      state_q;
  logic        h_q, write_q, wr_gap_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q, wr_enable_q, rd_enable_q;
  logic [22:0] word_q;
  logic [31:0] wdata_q, rsp_rdata_q;
  logic [3:0]  wstrb_q;
  logic [23:0] wr_addr_q, rd_addr_q;
  logic [15:0] wr_data_q;

  logic [23:0] hw_addr;
  logic [1:0]  cur_strb;
  logic [15:0] cur_wdata, merged;
  logic        unused_ok;

  always_comb begin
    hw_addr   = {word_q, h_q};
    cur_strb  = h_q ? wstrb_q[3:2] : wstrb_q[1:0];
    cur_wdata = h_q ? wdata_q[31:16] : wdata_q[15:0];
    merged    = {cur_strb[1] ? cur_wdata[15:8] : rd_data[15:8],
                 cur_strb[0] ? cur_wdata[7:0]  : rd_data[7:0]};
  end

  // Only address bits [24:2] select storage; the rest are deliberately dropped.
  assign unused_ok = (^req_addr) ^ (TIMEOUT_CYCLES == 0);

`ifdef SDRAM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;
  logic          timeout_hit;
  assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk_133mhz) begin
    if (reset) begin
      state_q     <= IDLE;
      h_q         <= 1'b0;
      write_q     <= 1'b0;
      wr_gap_q    <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      wr_enable_q <= 1'b0;
      rd_enable_q <= 1'b0;
      word_q      <= 23'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      wr_addr_q   <= 24'h0;
      rd_addr_q   <= 24'h0;
      wr_data_q   <= 16'h0;
`ifdef SDRAM_SEQ_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      rd_enable_q <= 1'b0;
      wr_enable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            word_q      <= req_addr[24:2];
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            h_q         <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            state_q     <= DECIDE;
          end
        end
        DECIDE: begin
          if (!write_q) begin
            state_q <= RD_ISSUE;
          end else begin
            case (cur_strb)
              2'b11: begin
                wr_data_q <= cur_wdata;
                state_q   <= WR_ISSUE;
              end
              2'b00:   state_q <= NEXT;
              default: state_q <= RD_ISSUE;
            endcase
          end
        end
        RD_ISSUE: begin
          if (!busy) begin
            rd_enable_q <= 1'b1;
            rd_addr_q   <= hw_addr;
            state_q     <= RD_WAIT;
`ifdef SDRAM_SEQ_TIMEOUT_EN
            timer_q     <= '0;
`endif
          end
        end
        RD_WAIT: begin
          if (rd_ready) begin
            if (write_q) begin
              wr_data_q <= merged;
              state_q   <= WR_ISSUE;
            end else begin
              if (h_q) rsp_rdata_q[31:16] <= rd_data;
              else     rsp_rdata_q[15:0]  <= rd_data;
              state_q <= NEXT;
            end
          end
`ifdef SDRAM_SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'hDEAD_BEEF;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
`endif
        end
        WR_ISSUE: begin
          if (!busy) begin
            wr_enable_q <= 1'b1;
            wr_addr_q   <= hw_addr;
            wr_gap_q    <= 1'b1;
            state_q     <= WR_WAIT;
`ifdef SDRAM_SEQ_TIMEOUT_EN
            timer_q     <= '0;
`endif
          end
        end
        WR_WAIT: begin
          // First cycle skipped so the controller has time to raise busy.
          wr_gap_q <= 1'b0;
          if (!wr_gap_q && !busy) begin
            state_q <= NEXT;
          end
`ifdef SDRAM_SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'hDEAD_BEEF;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
`endif
        end
        NEXT: begin
          if (!h_q) begin
            h_q     <= 1'b1;
            state_q <= DECIDE;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_enable = wr_enable_q;
  assign rd_addr   = rd_addr_q;
  assign rd_enable = rd_enable_q;

endmodule

// File: tb/tb_sdram_word_sequencer.sv
// tb/tb_sdram_word_sequencer.sv - table-driven scoreboard bench for sdram_word_sequencer
// Timeout sequence runs only when SDRAM_SEQ_TIMEOUT_EN is defined.
module tb_sdram_word_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [23:0] wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic        wr_enable, rd_enable, rd_ready, busy;
  logic        busy_model, busy_force;

  always #5 clk = ~clk;
  assign busy = busy_model | busy_force;

  sdram_word_sequencer #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_133mhz(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy)
  );

  typedef struct { logic wr; logic [23:0] addr; logic [15:0] data; } cmd_t;
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  cmd_t        cmd_q[$];
  rsp_t        rsp_q[$];
  vec_t        vecs[12];
  logic [15:0] mem[logic [23:0]];
  logic [15:0] exp_mem[logic [23:0]];
  int          errors = 0;
  int          checks = 0;
  int          lat = 3;
  logic        no_resp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Controller model and command/response monitor, sampled 1ns after each edge.
  initial begin
    int   cnt = 0;
    logic m_rd = 1'b0;
    logic [23:0] m_addr = 24'h0;
    logic prev_valid = 1'b0;
    cmd_t c;
    rsp_t r;
    busy_model = 1'b0;
    rd_ready = 1'b0;
    rd_data = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (rd_enable || wr_enable) begin
        chk("no_dual_cmd", {31'b0, rd_enable & wr_enable}, 32'h0);
        chk("cmd_while_idle", {31'b0, busy}, 32'h0);
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", {7'b0, wr_enable, rd_enable ? rd_addr : wr_addr}, 32'hFFFF_FFFF);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_kind", {31'b0, wr_enable}, {31'b0, c.wr});
          chk("cmd_addr", {8'h0, wr_enable ? wr_addr : rd_addr}, {8'h0, c.addr});
          if (c.wr) chk("cmd_wdata", {16'h0, wr_data}, {16'h0, c.data});
        end
      end
      if (rsp_valid && !prev_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_rdata, 32'hFFFF_FFFF);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
        end
      end
      prev_valid = rsp_valid;
      rd_ready = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          busy_model = 1'b0;
          if (m_rd && !no_resp) begin
            rd_ready = 1'b1;
            rd_data = mem.exists(m_addr) ? mem[m_addr] : 16'h0;
          end
        end
      end
      if (wr_enable) begin
        mem[wr_addr] = wr_data;
        busy_model = 1'b1; cnt = lat; m_rd = 1'b0;
      end
      if (rd_enable) begin
        busy_model = 1'b1; cnt = lat; m_rd = 1'b1; m_addr = rd_addr;
      end
    end
  end

  task automatic push_expect(input vec_t v);
    logic [23:0] a;
    logic [1:0]  s;
    logic [15:0] d, old, nw;
    for (int h = 0; h < 2; h++) begin
      a = {v.addr[24:2], 1'b0} + 24'(h);
      s = v.wstrb[2*h +: 2];
      d = v.wdata[16*h +: 16];
      if (!v.write) begin
        cmd_q.push_back('{1'b0, a, 16'h0});
      end else if (s == 2'b11) begin
        cmd_q.push_back('{1'b1, a, d});
        exp_mem[a] = d;
      end else if (s != 2'b00) begin
        old = exp_mem.exists(a) ? exp_mem[a] : 16'h0;
        nw = old;
        for (int b = 0; b < 2; b++) if (s[b]) nw[8*b +: 8] = d[8*b +: 8];
        cmd_q.push_back('{1'b0, a, 16'h0});
        cmd_q.push_back('{1'b1, a, nw});
        exp_mem[a] = nw;
      end
    end
    rsp_q.push_back('{v.exp_rdata, 1'b0});
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("req_accepted", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 3000) begin @(posedge clk); #1; n++; end
    chk("rsp_arrives", {31'b0, rsp_valid}, 32'h1);
    n = 0;
    while (rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'h0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'h0);
    chk({tag, "_enables"}, {30'b0, rd_enable, wr_enable}, 32'h0);
    chk({tag, "_addrs"}, {8'h0, rd_addr ^ wr_addr} | {8'h0, rd_addr}, 32'h0);
    chk({tag, "_wr_data"}, {16'h0, wr_data}, 32'h0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hCAFE_BABE, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hCAFE_BABE};
    vecs[2]  = '{1'b1, 32'h0000_0040, 32'h0000_5500, 4'b0010, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h7777_5534};
    vecs[4]  = '{1'b1, 32'h0000_0044, 32'h1357_9BDF, 4'h0, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0080, 32'hA1B2_C3D4, 4'b1100, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0084, 32'h1122_3344, 4'b0101, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0084, 32'h0,         4'h0, 32'hBB22_AA44};
    vecs[8]  = '{1'b0, 32'hFE00_0087, 32'h0,         4'h0, 32'hBB22_AA44};
    vecs[9]  = '{1'b1, 32'h01FF_FFFC, 32'h0BAD_F00D, 4'hF, 32'h0};
    vecs[10] = '{1'b0, 32'h01FF_FFFC, 32'h0,         4'h0, 32'h0BAD_F00D};
    vecs[11] = '{1'b0, 32'h0000_0080, 32'h0,         4'h0, 32'hA1B2_0000};
    mem[24'h20] = 16'h1234; exp_mem[24'h20] = 16'h1234;
    mem[24'h21] = 16'h7777; exp_mem[24'h21] = 16'h7777;
    mem[24'h42] = 16'hAAAA; exp_mem[24'h42] = 16'hAAAA;
    mem[24'h43] = 16'hBBBB; exp_mem[24'h43] = 16'hBBBB;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b1; busy_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < 12; i++) begin
      push_expect(vecs[i]);
      do_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      wait_rsp();
    end

    // Empty-strobe write: response in the fifth cycle after the acceptance cycle.
    rsp_q.push_back('{32'h0, 1'b0});
    do_req(1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'h0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("wstrb0_latency", n, 4);
    wait_rsp();

    // Controller busy throughout: no issue until busy falls, then the next cycle.
    @(negedge clk) busy_force = 1'b1;
    cmd_q.push_back('{1'b0, 24'h000008, 16'h0});
    cmd_q.push_back('{1'b0, 24'h000009, 16'h0});
    rsp_q.push_back('{32'hCAFE_BABE, 1'b0});
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    repeat (20) @(posedge clk);
    chk("no_issue_while_busy", cmd_q.size(), 2);
    @(negedge clk) busy_force = 1'b0;
    @(posedge clk); #1;
    chk("issue_after_busy_fall", {31'b0, rd_enable}, 32'h1);
    wait_rsp();

    // Reset while waiting for read data, then a read with a stalled consumer.
    lat = 8;
    cmd_q.push_back('{1'b0, 24'h000008, 16'h0});
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    n = 0;
    while (!rd_enable && n < 50) begin @(posedge clk); #1; n++; end
    chk("abort_rd_issued", {31'b0, rd_enable}, 32'h1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    @(negedge clk) reset = 1'b0;
    cmd_q.delete(); rsp_q.delete();
    @(posedge clk); #1;
    chk("ready_after_midreset", {31'b0, req_ready}, 32'h1);
    lat = 3;
    rsp_ready = 1'b0;
    cmd_q.push_back('{1'b0, 24'h000020, 16'h0});
    cmd_q.push_back('{1'b0, 24'h000021, 16'h0});
    rsp_q.push_back('{32'h7777_5534, 1'b0});
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    n = 0;
    while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("held_rsp_arrives", {31'b0, rsp_valid}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, rsp_valid}, 32'h1);
      chk("hold_rdata", rsp_rdata, 32'h7777_5534);
      chk("hold_req_ready", {31'b0, req_ready}, 32'h0);
    end
    @(negedge clk) rsp_ready = 1'b1;
    wait_rsp();

`ifdef SDRAM_SEQ_TIMEOUT_EN
    no_resp = 1'b1;
    cmd_q.push_back('{1'b0, 24'h000008, 16'h0});
    rsp_q.push_back('{32'hDEAD_BEEF, 1'b1});
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    wait_rsp();
    no_resp = 1'b0;
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
